dds_wave_gen: RTL and testbench
===============================

DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

Interface
REQ-001 Parameter FREQ_CTRL, default 32'd86, phase increment added per sys_clk cycle while running.
REQ-002 Parameter MUTE_CYC, default 16'd16, number of midscale cycles inserted on every waveform change (legal 1..65535).
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous assert, active-high.
REQ-005 wave_sel  input  5  waveform code, sampled only in a cycle where key_flag=1.
REQ-006 key_flag  input  1  single-cycle pulse marking a new wave_sel request.
REQ-007 dac_data  output  8  registered unsigned DAC sample, midscale 8'd128.
REQ-008 wave_active  output  1  registered, 1 only in state RUN.
REQ-009 sel_err  output  1  registered single-cycle pulse, invalid code received.

Function
REQ-010 Valid codes: 5'd1 square, 5'd11 triangle, 5'd23 sawtooth-up, 5'd13 sawtooth-down; all other codes are invalid.
REQ-011 States: IDLE, MUTE, RUN; current-wave register cur_wave holds the last accepted valid code.
REQ-012 IDLE: dac_data=128, accumulator held 0; key_flag with valid code -> latch code, load mute counter with MUTE_CYC-1, go MUTE.
REQ-013 MUTE: dac_data=128, accumulator held 0, counter decrements each cycle; counter=0 -> RUN next cycle.
REQ-014 RUN: 32-bit accumulator acc <= acc + FREQ_CTRL each cycle, wrapping modulo 2^32, no saturation.
REQ-015 Phase p = acc[31:24]; dac_data in the cycle after acc holds a value equals f(p) for that value (1-cycle latency); the first RUN cycle presents f(0).
REQ-016 Square: p<128 -> 255, else 0.
REQ-017 Triangle: p[7]=0 -> {p[6:0],1'b0}; p[7]=1 -> 8'd255 - {p[6:0],1'b0}.
REQ-018 Sawtooth-up: p; sawtooth-down: 8'd255 - p.
REQ-019 RUN + key_flag with valid code different from cur_wave -> latch code, reload mute counter, go MUTE.
REQ-020 RUN + key_flag with code equal to cur_wave -> ignored: no state change, accumulator continues, no glitch on dac_data.
REQ-021 key_flag with invalid code in any state -> sel_err=1 next cycle, go IDLE, dac_data=128 next cycle, cur_wave unchanged.
REQ-022 MUTE + key_flag with valid code (same or different) -> latch newest code, reload counter to MUTE_CYC-1, stay MUTE.
REQ-023 key_flag asserted in consecutive cycles: each cycle is evaluated independently per REQ-019..022.
REQ-024 wave_active=1 exactly in cycles where the registered state is RUN.

Reset
REQ-025 sys_rst=1 forces immediately, irrespective of clock: state IDLE, acc=0, mute counter=0, cur_wave=5'd0, dac_data=8'd128, wave_active=0, sel_err=0.
REQ-026 Reset asserted mid-RUN or mid-MUTE aborts the operation; after release the block waits in IDLE for a fresh key_flag.
REQ-027 Deassertion needs no key_flag masking beyond normal sampling; the first rising edge after release may accept a request.

Verification (FREQ_CTRL=32'h0100_0000, MUTE_CYC=4 unless stated)
REQ-028 Reset, key_flag with wave_sel=1 -> 4 cycles dac_data=128, then wave_active=1, dac_data 255 for 128 cycles, 0 for 128 cycles, repeating with period 256.
REQ-029 Triangle (code 11) in RUN -> dac_data 0,2,4,...,254, then 255,253,...,1, repeating; accumulator wrap 0xFF->0x00 produces no extra sample.
REQ-030 In RUN with saw-up, key_flag code 23 -> samples continue incrementing uninterrupted; then code 13 -> 4 midscale cycles, wave_active=0, then 255,254,...
REQ-031 key_flag code 7 during RUN -> sel_err high for exactly one cycle, dac_data=128, wave_active=0; later code 1 restarts from MUTE.
REQ-032 In MUTE after 2 cycles, key_flag code 11 -> midscale extended to 4 further cycles, then triangle starting at 0.
REQ-033 sys_rst pulsed asynchronously mid-RUN -> outputs reach reset values before the next clock edge; no output until a new key_flag.

Source files
------------

// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator: selectable square/triangle/saw outputs with
// a midscale mute window on every waveform change and a pulse flag for invalid selections.
module dds_wave_gen #(
  parameter logic [31:0] FREQ_CTRL = 32'd86,
  parameter logic [15:0] MUTE_CYC  = 16'd16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [4:0] wave_sel,
  input  logic       key_flag,
  output logic [7:0] dac_data,
  output logic       wave_active,
  output logic       sel_err
);

  typedef enum logic [1:0] {StIdle, StMute, StRun} state_e;

  localparam logic [4:0] WaveSquare   = 5'd1;
  localparam logic [4:0] WaveTriangle = 5'd11;
  localparam logic [4:0] WaveSawUp    = 5'd23;
  localparam logic [4:0] WaveSawDown  = 5'd13;
  localparam logic [7:0] MidScale     = 8'd128;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  wave_q, wave_d;
  logic [7:0]  dac_q, dac_d;
  logic        active_q, active_d;
  logic        err_q, err_d;

  function automatic logic is_valid(input logic [4:0] code);
    return (code == WaveSquare) || (code == WaveTriangle) ||
           (code == WaveSawUp) || (code == WaveSawDown);
  endfunction

  function automatic logic [7:0] wave_fn(input logic [4:0] code, input logic [7:0] p);
    logic [7:0] dbl;
    dbl = {p[6:0], 1'b0};
    case (code)
      WaveSquare:   return p[7] ? 8'd0 : 8'd255;
      WaveTriangle: return p[7] ? (8'd255 - dbl) : dbl;
      WaveSawUp:    return p;
      WaveSawDown:  return 8'd255 - p;
      default:      return MidScale;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wave_d  = wave_q;
    err_d   = 1'b0;
    if (key_flag && !is_valid(wave_sel)) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else if (key_flag && (state_q != StRun || wave_sel != wave_q)) begin
      // Same-code requests only bypass the mute window while already running.
      state_d = StMute;
      wave_d  = wave_sel;
      cnt_d   = MUTE_CYC - 16'd1;
    end else if (state_q == StMute) begin
      if (cnt_q == 16'd0) begin
        state_d = StRun;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    // The accumulator sits at zero outside RUN, so the first RUN sample is f(0).
    if (state_d == StRun) begin
      acc_d = acc_q + FREQ_CTRL;
      dac_d = wave_fn(wave_d, acc_q[31:24]);
    end else begin
      acc_d = 32'd0;
      dac_d = MidScale;
    end
    active_d = (state_d == StRun);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      acc_q    <= 32'd0;
      cnt_q    <= 16'd0;
      wave_q   <= 5'd0;
      dac_q    <= MidScale;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wave_q   <= wave_d;
      dac_q    <= dac_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign dac_data    = dac_q;
  assign wave_active = active_q;
  assign sel_err     = err_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen with FREQ_CTRL=32'h0100_0000 (one phase step per cycle)
// and MUTE_CYC=4.
module tb_dds_wave_gen;

  logic       sys_clk;
  logic       sys_rst;
  logic [4:0] wave_sel;
  logic       key_flag;
  logic [7:0] dac_data;
  logic       wave_active;
  logic       sel_err;

  int total;
  int bad;

  dds_wave_gen #(
    .FREQ_CTRL(32'h0100_0000),
    .MUTE_CYC (16'd4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wave_sel   (wave_sel),
    .key_flag   (key_flag),
    .dac_data   (dac_data),
    .wave_active(wave_active),
    .sel_err    (sel_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_dac, input logic exp_act,
                     input logic exp_err);
    total = total + 1;
    assert (dac_data === exp_dac) else begin
      bad = bad + 1;
      $error("FAIL %s dac_data got %0d want %0d", tag, dac_data, exp_dac);
    end
    total = total + 1;
    assert (wave_active === exp_act) else begin
      bad = bad + 1;
      $error("FAIL %s wave_active got %b want %b", tag, wave_active, exp_act);
    end
    total = total + 1;
    assert (sel_err === exp_err) else begin
      bad = bad + 1;
      $error("FAIL %s sel_err got %b want %b", tag, sel_err, exp_err);
    end
  endtask

  // One-cycle request; afterwards wave_sel holds junk that must be ignored without key_flag.
  task automatic pulse(input logic [4:0] code);
    wave_sel = code;
    key_flag = 1'b1;
    tick();
    key_flag = 1'b0;
    wave_sel = 5'd7;
  endtask

  // Checks the current cycle plus three more: four midscale cycles in total.
  task automatic mute_check(input string tag);
    chk(tag, 8'd128, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      chk(tag, 8'd128, 1'b0, 1'b0);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    sys_rst  = 1'b1;
    key_flag = 1'b0;
    wave_sel = 5'd0;
    #3;
    chk("reset_async", 8'd128, 1'b0, 1'b0);
    repeat (2) tick();
    chk("reset_held", 8'd128, 1'b0, 1'b0);
    sys_rst = 1'b0;
    tick();
    chk("idle_after_reset", 8'd128, 1'b0, 1'b0);

    // Square: 255 for 128 samples, 0 for 128, period 256.
    pulse(5'd1);
    mute_check("square_mute");
    for (int k = 0; k < 300; k++) begin
      tick();
      chk("square_run", ((k % 256) < 128) ? 8'd255 : 8'd0, 1'b1, 1'b0);
    end

    // Triangle: 0,2,..,254 then 255,253,..,1, no duplicate at wrap.
    pulse(5'd11);
    mute_check("tri_mute");
    for (int k = 0; k < 520; k++) begin
      int m;
      m = k % 256;
      tick();
      chk("tri_run", (m < 128) ? 8'(2 * m) : 8'(511 - 2 * m), 1'b1, 1'b0);
    end

    // Saw-up; re-selecting the same code must not interrupt it.
    pulse(5'd23);
    mute_check("sawup_mute");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("sawup_run", 8'(k), 1'b1, 1'b0);
    end
    pulse(5'd23);
    chk("sawup_same_code", 8'd10, 1'b1, 1'b0);
    tick();
    chk("sawup_continue", 8'd11, 1'b1, 1'b0);

    // Saw-down after a mute window.
    pulse(5'd13);
    mute_check("sawdn_mute");
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("sawdn_run", 8'(255 - k), 1'b1, 1'b0);
    end

    // Invalid code during RUN: one-cycle error pulse, then idle.
    pulse(5'd7);
    chk("invalid_pulse", 8'd128, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("invalid_idle", 8'd128, 1'b0, 1'b0);
    end

    // Re-request in MUTE after two cycles restarts a full four-cycle window.
    pulse(5'd1);
    chk("remute_first", 8'd128, 1'b0, 1'b0);
    tick();
    chk("remute_second", 8'd128, 1'b0, 1'b0);
    pulse(5'd11);
    mute_check("remute_ext");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("remute_tri", 8'(2 * k), 1'b1, 1'b0);
    end

    // Asynchronous reset mid-RUN takes effect before the next edge.
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_rst_mid_run", 8'd128, 1'b0, 1'b0);
    tick();
    chk("async_rst_held", 8'd128, 1'b0, 1'b0);
    sys_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_idle", 8'd128, 1'b0, 1'b0);
    end

    // A request at the very first edge after release is accepted.
    sys_rst = 1'b1;
    #2;
    wave_sel = 5'd23;
    key_flag = 1'b1;
    sys_rst  = 1'b0;
    tick();
    key_flag = 1'b0;
    wave_sel = 5'd7;
    mute_check("first_edge_mute");
    tick();
    chk("first_edge_run", 8'd0, 1'b1, 1'b0);

    // Back-to-back requests: same code ignored, then a new code mutes.
    wave_sel = 5'd23;
    key_flag = 1'b1;
    tick();
    chk("b2b_same", 8'd1, 1'b1, 1'b0);
    wave_sel = 5'd13;
    tick();
    key_flag = 1'b0;
    chk("b2b_new", 8'd128, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
